// File: rtl/exu_muldiv.sv
// Multi-cycle RV32M execute unit: shift-add multiply and restoring divide, one bit per cycle.
// Operands are reduced to magnitudes at accept; signs are reapplied in FIX.
module exu_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            md_op,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] md_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             r_state, w_state_next;
    logic [2:0]         r_op;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [W-1:0]       r_opnd;      // multiplicand (mul) or divisor (div), as magnitude
    logic [2*W-1:0]     r_acc;       // product; low half doubles as dividend/quotient
    logic [W-1:0]       r_rem;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [W-1:0]       r_result;

    logic               w_accept;
    logic               w_is_div;
    logic               w_sa, w_sb;
    logic [W-1:0]       w_abs_a, w_abs_b;
    logic [W-1:0]       w_min;
    logic               w_div_zero, w_div_ovf, w_mul_zero, w_fast;
    logic [W:0]         w_mul_sum;
    logic [2*W-1:0]     w_mul_next;
    logic [W:0]         w_div_shift, w_div_diff;
    logic [2*W-1:0]     w_prod;
    logic [W-1:0]       w_quo, w_remv, w_fix_res;

    assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
    assign w_is_div   = md_op[2];
    assign w_sa       = rs1_data[W-1] && (md_op == 3'd1 || md_op == 3'd2 || md_op == 3'd4 || md_op == 3'd6);
    assign w_sb       = rs2_data[W-1] && (md_op == 3'd1 || md_op == 3'd4 || md_op == 3'd6);
    assign w_abs_a    = w_sa ? -rs1_data : rs1_data;
    assign w_abs_b    = w_sb ? -rs2_data : rs2_data;
    assign w_min      = {1'b1, {(W-1){1'b0}}};
    assign w_div_zero = w_is_div && (rs2_data == '0);
    assign w_div_ovf  = w_is_div && !md_op[0] && (rs1_data == w_min) && (rs2_data == '1);
    assign w_mul_zero = !w_is_div && ((rs1_data == '0) || (rs2_data == '0));
    assign w_fast     = w_div_zero || w_div_ovf || w_mul_zero;

    // Multiplier bits sit in the low half and shift out as the sum shifts in from the top.
    assign w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    assign w_mul_next  = {w_mul_sum, r_acc[W-1:1]};
    assign w_div_shift = {r_rem, r_acc[W-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_remv = r_neg_rem ? -r_rem : r_rem;

    always_comb begin
        w_fix_res = w_prod[W-1:0];
        case (r_op)
            3'd1, 3'd2, 3'd3: w_fix_res = w_prod[2*W-1:W];
            3'd4, 3'd5:       w_fix_res = w_quo;
            3'd6, 3'd7:       w_fix_res = w_remv;
            default:          w_fix_res = w_prod[W-1:0];
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_fast ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == CW'(W-1)) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_tag     <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op      <= md_op;
                    r_tag     <= rd_tag;
                    r_cnt     <= '0;
                    r_neg_res <= w_sa ^ w_sb;
                    r_neg_rem <= w_sa;
                    r_opnd    <= w_is_div ? w_abs_b : w_abs_a;
                    r_rem     <= '0;
                    r_acc     <= {{W{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    // Fast-path results are loaded pre-signed so FIX only selects them.
                    if (w_fast) begin
                        r_neg_res <= 1'b0;
                        r_neg_rem <= 1'b0;
                        if (w_mul_zero) begin
                            r_acc <= '0;
                        end else if (w_div_zero) begin
                            r_acc <= {{W{1'b0}}, {W{1'b1}}};
                            r_rem <= rs1_data;
                        end else begin
                            r_acc <= {{W{1'b0}}, w_min};
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op[2]) begin
                        r_rem        <= w_div_diff[W] ? w_div_shift[W-1:0] : w_div_diff[W-1:0];
                        r_acc[W-1:0] <= {r_acc[W-2:0], ~w_div_diff[W]};
                    end else begin
                        r_acc <= w_mul_next;
                    end
                end
                S_FIX:   r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign md_result = r_result;
    assign out_tag   = r_tag;
endmodule

// File: tb/tb_exu_muldiv.sv
// Randomised bench for exu_muldiv against a plain-arithmetic RV32M model.
module tb_exu_muldiv;
    localparam int W = 32;
    localparam int T = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   md_op = '0;
    logic [W-1:0] rs1_data = '0;
    logic [W-1:0] rs2_data = '0;
    logic [T-1:0] rd_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] md_result;
    logic [T-1:0] out_tag;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic         exp_armed = 1'b0;
    logic [W-1:0] exp_res = '0;
    logic [T-1:0] exp_tag = '0;

    exu_muldiv #(.DATA_WIDTH(W), .TAG_WIDTH(T)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .md_op(md_op), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_tag(rd_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .md_result(md_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint p;
        case (op)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = longint'(64'(ua * ub) >> 32);
            3'd4: p = (b == 0) ? -1 : sa / sb;
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: p = (b == 0) ? sa : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return (a == 0) || (b == 0);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Output checker: every cycle with a live result, plus handshake invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_vs_in_ready", busy, !in_ready);
            if (out_valid) begin
                check("valid_when_expected", exp_armed, 1);
                check("in_ready_in_done", in_ready, 0);
                if (exp_armed) begin
                    check("md_result", md_result, exp_res);
                    check("out_tag", out_tag, exp_tag);
                end
            end
        end
    end

    // end_mode 0: normal handshake after 'hold' stalled cycles; 1: flush while in DONE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [T-1:0] tag, input int hold, input int end_mode);
        int lat;
        logic [31:0] e;
        bit fast;
        e = model(op, a, b);
        fast = is_fast(op, a, b);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        md_op = op; rs1_data = a; rs2_data = b; rd_tag = tag;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; md_op = 3'($urandom); rd_tag = T'($urandom);
        exp_res = e; exp_tag = tag; exp_armed = 1'b1;
        check("busy_after_accept", busy, 1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), fast ? 32'd1 : 32'(W + 1));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        check("valid_held", out_valid, 1);
        if (end_mode == 1) begin
            flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            exp_armed = 1'b0;
            flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
            check("flush_done_busy", busy, 0);
        end else begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0; exp_armed = 1'b0;
        end
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        $display("op=%0d a=%h b=%h tag=%0d exp=%h lat=%0d hold=%0d mode=%0d",
                 op, a, b, tag, e, lat, hold, end_mode);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_md_result", md_result, 0);
        check("rst_out_tag", out_tag, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("pin_mul", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("pin_mulh", model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("pin_mulhu", model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("pin_div", model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("pin_rem", model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("pin_divu", model(3'd5, 32'd100, 32'd7), 32'd14);
        check("pin_remu", model(3'd7, 32'd100, 32'd7), 32'd2);
        check("pin_divu0", model(3'd5, 32'd100, 32'd0), 32'hFFFF_FFFF);
        check("pin_remu0", model(3'd7, 32'd100, 32'd0), 32'd100);
        check("pin_div_ovf", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("pin_rem_ovf", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 10, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 2, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd10, 0, 0);
        run_op(3'd5, 32'd100, 32'd0, 5'd11, 0, 0);
        run_op(3'd7, 32'd100, 32'd0, 5'd12, 3, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 0);
        run_op(3'd0, 32'd0, 32'h1234_5678, 5'd15, 0, 0);

        // Flush mid-CALC (count = 10) with a competing request that must be ignored.
        @(negedge clk);
        md_op = 3'd5; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'd3; rd_tag = 5'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_calc_valid", out_valid, 0);
        check("flush_calc_in_ready", in_ready, 1);
        check("flush_calc_busy", busy, 0);
        $display("flush in CALC: in_ready=%0d busy=%0d", in_ready, busy);
        repeat (40) @(negedge clk);

        run_op(3'd4, 32'hFFFF_FF00, 32'd5, 5'd21, 0, 1);
        run_op(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd22, 0, 0);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        md_op = 3'd1; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0; rd_tag = 5'd23; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_md_result", md_result, 0);
        check("arst_out_tag", out_tag, 0);
        #2;
        rst_n = 1'b1;
        $display("async reset mid-CALC: md_result=%h out_tag=%0d", md_result, out_tag);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), T'($urandom),
                   $urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
